// File: rtl/ula_pipe.sv
// ula_pipe -- single-issue ALU with a post-op shifter and an iterative divider.
//
// One bundle is in flight at a time: IDLE accepts, EXEC evaluates, DIV runs the
// restoring divider (one quotient bit per cycle), and DONE presents the result
// until the consumer takes it.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready operand bundle handshake (in_ready only in IDLE)
//   a, b                operands, WIDTH bits
//   crtl_ula            000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or,
//                       110 not A, 111 pass B
//   crtl_des            00 bypass, 01 shl 1, 10 lsr 1, 11 asr 1
//   out_valid/out_ready result handshake
//   c                   shifted result
//   flags               {div_by_zero, overflow, carry, zero}
//
// Build option: define ULA_PIPE_FLAGS_EN to compute flags; otherwise flags are
// tied to zero and no flag logic exists.
module ula_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       crtl_ula,
    input  logic [1:0]       crtl_des,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [3:0]       flags
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [1:0]       des_q;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             fin;      // result produced this cycle
    logic [WIDTH-1:0] op_res;   // unshifted result
    logic [WIDTH-1:0] sh_res;   // shifted result
    logic [WIDTH:0]   trial;    // divider trial subtraction, MSB = borrow

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && in_ready;
    assign c         = c_q;

    // The remainder stays below B, so shifting in one dividend bit and
    // subtracting B always fits WIDTH+1 bits.
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, b_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        op_res  = '0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) state_d = EXEC;
            end
            EXEC: begin
                fin = 1'b1;
                case (op_q)
                    3'b000: op_res = a_q + b_q;
                    3'b001: op_res = a_q - b_q;
                    3'b010: op_res = a_q * b_q;
                    3'b011: begin
                        if (b_q == '0) begin
                            op_res = '1;
                        end else begin
                            fin     = 1'b0;
                            state_d = DIV;
                            rem_d   = '0;
                            quo_d   = a_q;
                            cnt_d   = '0;
                        end
                    end
                    3'b100: op_res = a_q & b_q;
                    3'b101: op_res = a_q | b_q;
                    3'b110: op_res = ~a_q;
                    default: op_res = b_q;
                endcase
                if (fin) state_d = DONE;
            end
            DIV: begin
                // Dividend bits shift out of quo while quotient bits shift in.
                rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    fin     = 1'b1;
                    op_res  = quo_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (des_q)
            2'b01:   sh_res = {op_res[WIDTH-2:0], 1'b0};
            2'b10:   sh_res = {1'b0, op_res[WIDTH-1:1]};
            2'b11:   sh_res = {op_res[WIDTH-1], op_res[WIDTH-1:1]};
            default: sh_res = op_res;
        endcase
    end

    assign c_d = fin ? sh_res : c_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            des_q   <= '0;
            c_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= crtl_ula;
                des_q <= crtl_des;
            end
        end
    end

`ifdef ULA_PIPE_FLAGS_EN
    logic [2*WIDTH-1:0] prod_w;
    logic [3:0]         flags_q, flags_d;
    logic               cy, ov, dz;

    assign prod_w = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    always_comb begin
        cy = 1'b0;
        ov = 1'b0;
        dz = 1'b0;
        // Operation flags only arise in EXEC; a divider completion leaves them clear.
        if (state_q == EXEC) begin
            case (op_q)
                3'b000: begin
                    cy = (op_res < a_q);  // wrapped sum is below an operand iff carry-out
                    ov = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (op_res[WIDTH-1] != a_q[WIDTH-1]);
                end
                3'b001: begin
                    cy = (a_q < b_q);
                    ov = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (op_res[WIDTH-1] != a_q[WIDTH-1]);
                end
                3'b010: cy = ((prod_w >> WIDTH) != '0);
                3'b011: dz = (b_q == '0);
                default: ;
            endcase
        end
        if (des_q == 2'b01) cy = cy | op_res[WIDTH-1];
        flags_d = {dz, ov, cy, (sh_res == '0)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (fin) begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

endmodule

// File: doc/ula_pipe.md
ULA_PIPE -- requirements
Module: ula_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits (legal range 4..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand/command bundle valid.
REQ-005 in_ready  output  1  block can accept a bundle this cycle.
REQ-006 a, b  input  WIDTH each  operands A and B.
REQ-007 crtl_ula  input  3  operation: 000 add, 001 sub, 010 mul, 011 div, 100 AND, 101 OR, 110 NOT A, 111 pass B.
REQ-008 crtl_des  input  2  post-op shift: 00 bypass, 01 shift left 1, 10 logical right 1, 11 arithmetic right 1.
REQ-009 out_valid  output  1  result bundle valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 c  output  WIDTH  shifted result.
REQ-012 flags  output  4  {div_by_zero, overflow, carry, zero}, bit 0 = zero.

Function
REQ-013 FSM states SHALL be IDLE, EXEC, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Acceptance: in_valid && in_ready at an edge SHALL register a, b, crtl_ula, crtl_des and move IDLE->EXEC.
REQ-015 EXEC, non-divide op: next edge SHALL register shifted result into c, flags, and move to DONE (acceptance-to-out_valid latency 2 cycles).
REQ-016 EXEC, div with B != 0: SHALL move to DIV and run a restoring divider, one quotient bit per cycle, WIDTH cycles, then DONE (latency WIDTH+2).
REQ-017 EXEC, div with B == 0: SHALL go straight to DONE with c = all ones (before shift), div_by_zero = 1, latency 2.
REQ-018 DONE: out_valid = 1; c and flags SHALL hold stable until out_valid && out_ready, then state SHALL return to IDLE; no new input accepted in the same cycle (back-to-back throughput one op per 3 cycles minimum).
REQ-019 Arithmetic modulo 2^WIDTH; mul keeps low WIDTH bits; div is unsigned, quotient only.
REQ-020 carry: add carry-out; sub borrow (A < B unsigned); mul 1 if upper WIDTH product bits nonzero; shift-left SHALL OR in the shifted-out MSB; else 0.
REQ-021 overflow: signed overflow for add/sub only; 0 otherwise.
REQ-022 zero: 1 when final shifted c == 0.
REQ-023 Shift SHALL apply after the op to every op, including div and div-by-zero results.
REQ-024 in_valid while not IDLE SHALL be ignored; inputs outside acceptance cycle have no effect.

Reset
REQ-025 rst high at an edge SHALL force IDLE, c = 0, flags = 0, out_valid = 0, divider state cleared; in_ready = 1 the cycle after.
REQ-026 rst SHALL override any in-progress op including mid-DIV and a pending DONE; the aborted result is never presented.
REQ-027 rst and in_valid asserted together: bundle SHALL NOT be accepted.

Configuration
REQ-028 Macro ULA_PIPE_FLAGS_EN: defined -> flags computed per REQ-020..022 and REQ-017; undefined -> flags tied to 0 and no flag logic synthesised, all other behaviour unchanged.

Verification
REQ-029 WIDTH=8: add A=0xFF, B=0x01, des=00 -> out_valid 2 cycles after accept, c=0x00, flags zero=1 carry=1 overflow=0.
REQ-030 WIDTH=8: div A=200, B=7, des=01 -> out_valid at accept+10, c=0x38 (28<<1), div_by_zero=0.
REQ-031 WIDTH=8: div A=5, B=0, des=00 -> out_valid at accept+2, c=0xFF, div_by_zero=1.
REQ-032 Backpressure: sub A=0x80, B=0x01, out_ready held 0 for 5 cycles -> c=0x7F, overflow=1, stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-033 rst pulsed during DIV cycle 3 -> next cycle out_valid=0, c=0, in_ready=1; a new add accepted afterwards completes normally.
REQ-034 WIDTH=16, macro undefined: mul 0x0100*0x0100, des=11 -> c=0x0000, flags=0.
